// File: rtl/ps2_piano_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_piano_pkg
//  Description : Shared types, scan-code constants and the set-2 scan-code to
//                piano-note lookup for the PS/2 note scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
package ps2_piano_pkg;

    localparam int NUM_KEYS = 13;

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_OCT_DN = 8'h1A;
    localparam logic [7:0] SC_OCT_UP = 8'h22;

    // Parser states, kept as plain encoded constants for legacy tools
    typedef logic [1:0] pstate_t;
    localparam pstate_t ST_IDLE     = 2'd0;
    localparam pstate_t ST_GOT_E0   = 2'd1;
    localparam pstate_t ST_GOT_F0   = 2'd2;
    localparam pstate_t ST_GOT_E0F0 = 2'd3;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } key_map_t;

    // Map a set-2 scan code onto the 13 piano keys (C..C')
    function automatic key_map_t scan_to_note(input logic [7:0] code);
        key_map_t r;
        r.valid = 1'b1;
        r.idx   = 4'd0;
        case (code)
            8'h1C:   r.idx = 4'd0;
            8'h1D:   r.idx = 4'd1;
            8'h1B:   r.idx = 4'd2;
            8'h24:   r.idx = 4'd3;
            8'h23:   r.idx = 4'd4;
            8'h2B:   r.idx = 4'd5;
            8'h2C:   r.idx = 4'd6;
            8'h34:   r.idx = 4'd7;
            8'h35:   r.idx = 4'd8;
            8'h33:   r.idx = 4'd9;
            8'h3C:   r.idx = 4'd10;
            8'h3B:   r.idx = 4'd11;
            8'h42:   r.idx = 4'd12;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_seq_parser.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_seq_parser
//  Description : PS/2 set-2 make/break sequence parser with prefix timeout.
//                Emits a single-cycle event, aligned with the final byte of a
//                plain make or break sequence; extended codes are dropped.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_seq_parser
    import ps2_piano_pkg::*;
#(
    parameter int PREFIX_TIMEOUT = 1_000_000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       byte_en_i,
    input  logic [7:0] byte_i,
    output logic       evt_valid_o,
    output logic       evt_break_o,
    output logic [7:0] evt_code_o
);

    localparam int             CW       = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(PREFIX_TIMEOUT - 1);

    pstate_t       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          w_is_prefix;

    assign w_is_prefix = (byte_i == SC_E0) || (byte_i == SC_F0);

    // Event is combinational so the top can react on the same edge as the byte
    assign evt_valid_o = byte_en_i && !w_is_prefix &&
                         ((state_q == ST_IDLE) || (state_q == ST_GOT_F0));
    assign evt_break_o = (state_q == ST_GOT_F0);
    assign evt_code_o  = byte_i;

    // Next-state: a received byte always wins over an expiring prefix timeout
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (byte_en_i) begin
            cnt_d = '0;
            if (byte_i == SC_E0) begin
                state_d = ST_GOT_E0;
            end else if (byte_i == SC_F0) begin
                case (state_q)
                    ST_IDLE:   state_d = ST_GOT_F0;
                    ST_GOT_E0: state_d = ST_GOT_E0F0;
                    default:   state_d = state_q;
                endcase
            end else begin
                state_d = ST_IDLE;
            end
        end else if (state_q != ST_IDLE) begin
            if (cnt_q == CNT_LAST) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State and timeout registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_note_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_note_scheduler
//  Description : Tracks held piano keys from PS/2 make/break events, applies
//                monophonic last-note priority and an octave register, and
//                produces note-on/off strobes for the tone generator.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_note_scheduler
    import ps2_piano_pkg::*;
#(
    parameter int PREFIX_TIMEOUT = 1_000_000,
    parameter int OCTAVE_RESET   = 4
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic [7:0]          received_data,
    input  logic                received_data_en,
    output logic [3:0]          note,
    output logic [2:0]          octave,
    output logic                note_active,
    output logic                note_on,
    output logic                note_off,
    output logic [NUM_KEYS-1:0] held_keys,
    output logic [7:0]          last_byte
);

    logic                evt_valid, evt_break;
    logic [7:0]          evt_code;
    key_map_t            w_key;
    logic [NUM_KEYS-1:0] w_key_mask, w_remain;
    logic [3:0]          w_low_idx;

    logic [3:0]          note_q, note_d;
    logic [2:0]          octave_q, octave_d;
    logic                active_q, active_d;
    logic                on_q, on_d;
    logic                off_q, off_d;
    logic [NUM_KEYS-1:0] held_q, held_d;
    logic                up_held_q, up_held_d;
    logic                dn_held_q, dn_held_d;
    logic [7:0]          last_q;

    ps2_seq_parser #(
        .PREFIX_TIMEOUT (PREFIX_TIMEOUT)
    ) u_parser (
        .clk_i       (CLOCK_50),
        .rst_ni      (resetn),
        .byte_en_i   (received_data_en),
        .byte_i      (received_data),
        .evt_valid_o (evt_valid),
        .evt_break_o (evt_break),
        .evt_code_o  (evt_code)
    );

    assign w_key      = scan_to_note(evt_code);
    assign w_key_mask = NUM_KEYS'(1) << w_key.idx;
    assign w_remain   = held_q & ~w_key_mask;

    // Lowest-index key still held once the current key is released
    always_comb begin
        w_low_idx = 4'd0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (w_remain[i]) w_low_idx = 4'(i);
        end
    end

    // Key tracking, note priority and octave stepping
    always_comb begin
        note_d    = note_q;
        octave_d  = octave_q;
        active_d  = active_q;
        on_d      = 1'b0;
        off_d     = 1'b0;
        held_d    = held_q;
        up_held_d = up_held_q;
        dn_held_d = dn_held_q;
        if (evt_valid) begin
            if (w_key.valid) begin
                if (!evt_break) begin
                    // Typematic repeats of an already-held key are ignored
                    if ((held_q & w_key_mask) == '0) begin
                        held_d   = held_q | w_key_mask;
                        note_d   = w_key.idx;
                        active_d = 1'b1;
                        on_d     = 1'b1;
                    end
                end else if ((held_q & w_key_mask) != '0) begin
                    held_d = w_remain;
                    if (active_q && (w_key.idx == note_q)) begin
                        if (w_remain != '0) begin
                            note_d = w_low_idx;
                            on_d   = 1'b1;
                        end else begin
                            active_d = 1'b0;
                            off_d    = 1'b1;
                        end
                    end
                end
            end else if (evt_code == SC_OCT_UP) begin
                if (evt_break) begin
                    up_held_d = 1'b0;
                end else if (!up_held_q) begin
                    up_held_d = 1'b1;
                    if (octave_q != 3'd7) octave_d = octave_q + 3'd1;
                end
            end else if (evt_code == SC_OCT_DN) begin
                if (evt_break) begin
                    dn_held_d = 1'b0;
                end else if (!dn_held_q) begin
                    dn_held_d = 1'b1;
                    if (octave_q != 3'd0) octave_d = octave_q - 3'd1;
                end
            end
        end
    end

    // Output and tracking registers
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            note_q    <= 4'd0;
            octave_q  <= 3'(OCTAVE_RESET);
            active_q  <= 1'b0;
            on_q      <= 1'b0;
            off_q     <= 1'b0;
            held_q    <= '0;
            up_held_q <= 1'b0;
            dn_held_q <= 1'b0;
            last_q    <= 8'h00;
        end else begin
            note_q    <= note_d;
            octave_q  <= octave_d;
            active_q  <= active_d;
            on_q      <= on_d;
            off_q     <= off_d;
            held_q    <= held_d;
            up_held_q <= up_held_d;
            dn_held_q <= dn_held_d;
            if (received_data_en) last_q <= received_data;
        end
    end

    assign note        = note_q;
    assign octave      = octave_q;
    assign note_active = active_q;
    assign note_on     = on_q;
    assign note_off    = off_q;
    assign held_keys   = held_q;
    assign last_byte   = last_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_note_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_note_scheduler
//  Description : Directed, self-checking bench for ps2_note_scheduler with a
//                behavioural reference model feeding an expectation queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_note_scheduler;

    localparam int T = 16;

    logic        CLOCK_50 = 1'b0;
    logic        resetn = 1'b1;
    logic [7:0]  received_data = 8'h00;
    logic        received_data_en = 1'b0;
    logic [3:0]  note;
    logic [2:0]  octave;
    logic        note_active, note_on, note_off;
    logic [12:0] held_keys;
    logic [7:0]  last_byte;

    ps2_note_scheduler #(
        .PREFIX_TIMEOUT (T),
        .OCTAVE_RESET   (4)
    ) dut (
        .CLOCK_50         (CLOCK_50),
        .resetn           (resetn),
        .received_data    (received_data),
        .received_data_en (received_data_en),
        .note             (note),
        .octave           (octave),
        .note_active      (note_active),
        .note_on          (note_on),
        .note_off         (note_off),
        .held_keys        (held_keys),
        .last_byte        (last_byte)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic        on;
        logic        off;
        logic        act;
        logic [3:0]  note;
        logic [2:0]  oct;
        logic [12:0] held;
        logic [7:0]  lb;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    logic [7:0] KEYCODES [13] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C,
                                  8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42};

    // Reference model state
    logic        m_e0, m_f0, m_act, m_up, m_dn;
    int          m_wait;
    logic [3:0]  m_note;
    logic [2:0]  m_oct;
    logic [12:0] m_held;
    logic [7:0]  m_lb;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic int key_of(input logic [7:0] b);
        for (int i = 0; i < 13; i++) if (KEYCODES[i] == b) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_e0 = 0; m_f0 = 0; m_act = 0; m_up = 0; m_dn = 0; m_wait = 0;
        m_note = 0; m_oct = 3'd4; m_held = 0; m_lb = 8'h00;
    endtask

    task automatic push_exp(input logic on, input logic off);
        exp_t e;
        e.on = on; e.off = off; e.act = m_act; e.note = m_note;
        e.oct = m_oct; e.held = m_held; e.lb = m_lb;
        sb.push_back(e);
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic on, off, brk, ext;
        int   k;
        on = 0; off = 0;
        m_lb = b; m_wait = 0;
        if (b == 8'hE0) begin
            m_e0 = 1; m_f0 = 0;
        end else if (b == 8'hF0) begin
            m_f0 = 1;
        end else begin
            ext = m_e0; brk = m_f0; m_e0 = 0; m_f0 = 0;
            k = key_of(b);
            if (!ext && k >= 0) begin
                if (!brk && !m_held[k]) begin
                    m_held[k] = 1; m_note = 4'(k); m_act = 1; on = 1;
                end else if (brk && m_held[k]) begin
                    m_held[k] = 0;
                    if (m_act && m_note == 4'(k)) begin
                        if (m_held != 0) begin
                            for (int i = 12; i >= 0; i--) if (m_held[i]) m_note = 4'(i);
                            on = 1;
                        end else begin
                            m_act = 0; off = 1;
                        end
                    end
                end
            end else if (!ext && b == 8'h22) begin
                if (brk) m_up = 0;
                else if (!m_up) begin m_up = 1; if (m_oct < 7) m_oct++; end
            end else if (!ext && b == 8'h1A) begin
                if (brk) m_dn = 0;
                else if (!m_dn) begin m_dn = 1; if (m_oct > 0) m_oct--; end
            end
        end
        push_exp(on, off);
    endtask

    task automatic check_pop(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, ".queue_empty"}, 16'd0, 16'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, ".note_on"},     16'(note_on),     16'(e.on));
            chk({tag, ".note_off"},    16'(note_off),    16'(e.off));
            chk({tag, ".note_active"}, 16'(note_active), 16'(e.act));
            chk({tag, ".note"},        16'(note),        16'(e.note));
            chk({tag, ".octave"},      16'(octave),      16'(e.oct));
            chk({tag, ".held_keys"},   16'(held_keys),   16'(e.held));
            chk({tag, ".last_byte"},   16'(last_byte),   16'(e.lb));
        end
    endtask

    // Called at a falling edge; the byte is consumed on the next rising edge
    task automatic send(input logic [7:0] b);
        received_data    = b;
        received_data_en = 1'b1;
        model_byte(b);
        @(negedge CLOCK_50);
        received_data_en = 1'b0;
        check_pop($sformatf("byte_%02h", b));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            m_wait++;
            if ((m_e0 || m_f0) && m_wait >= T) begin m_e0 = 0; m_f0 = 0; end
            push_exp(1'b0, 1'b0);
            @(negedge CLOCK_50);
            check_pop("idle");
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".note"},        16'(note),        16'd0);
        chk({tag, ".octave"},      16'(octave),      16'd4);
        chk({tag, ".note_active"}, 16'(note_active), 16'd0);
        chk({tag, ".note_on"},     16'(note_on),     16'd0);
        chk({tag, ".note_off"},    16'(note_off),    16'd0);
        chk({tag, ".held_keys"},   16'(held_keys),   16'd0);
        chk({tag, ".last_byte"},   16'(last_byte),   16'd0);
    endtask

    initial begin
        model_reset();
        #5 resetn = 1'b0;
        #2 chk_reset_values("reset");
        @(negedge CLOCK_50);
        resetn = 1'b1;
        @(negedge CLOCK_50);

        // Single press and release
        send(8'h1C);
        chk("press1C.on", 16'(note_on), 16'd1);
        chk("press1C.held", 16'(held_keys), 16'h0001);
        idle(2);
        send(8'hF0); send(8'h1C);
        chk("rel1C.off", 16'(note_off), 16'd1);
        chk("rel1C.held", 16'(held_keys), 16'h0000);
        idle(1);

        // Last-note priority, release of sounding note falls back to held key
        send(8'h1C); send(8'h23);
        chk("press23.note", 16'(note), 16'd4);
        send(8'hF0); send(8'h23);
        chk("rel23.note", 16'(note), 16'd0);
        chk("rel23.on", 16'(note_on), 16'd1);
        chk("rel23.off", 16'(note_off), 16'd0);
        send(8'hF0); send(8'h1C);

        // Typematic repeat
        send(8'h1C); send(8'h1C); send(8'h1C);
        chk("typematic.held", 16'(held_keys), 16'h0001);
        send(8'hF0); send(8'h1C);

        // Lowest remaining key wins; releasing a non-sounding key is silent
        send(8'h42); send(8'h2B); send(8'h1D);
        send(8'hF0); send(8'h1D);
        chk("lowest.note", 16'(note), 16'd5);
        send(8'hF0); send(8'h42);
        send(8'hF0); send(8'h2B);
        send(8'hF0); send(8'h2B);

        // Octave stepping with saturation and repeat suppression
        for (int i = 0; i < 4; i++) begin
            send(8'h22); send(8'h22); send(8'hF0); send(8'h22);
        end
        chk("oct.sat7", 16'(octave), 16'd7);
        send(8'h1A); send(8'hF0); send(8'h1A);
        chk("oct.down6", 16'(octave), 16'd6);

        // Extended codes and ignored bytes
        send(8'hE0); send(8'h1C);
        send(8'hE0); send(8'hF0); send(8'h1C);
        chk("ext.held", 16'(held_keys), 16'h0000);
        send(8'hAA); send(8'hFA); send(8'hFE);

        // Prefix timeout: expired prefix -> make; byte on the last cycle -> break
        send(8'hF0); idle(T); send(8'h1C);
        chk("timeout.make", 16'(note_on), 16'd1);
        send(8'hF0); idle(T - 1); send(8'h1C);
        chk("timeout.edge_break", 16'(note_off), 16'd1);

        // Asynchronous reset in the middle of a break sequence
        send(8'h1C); send(8'h22); send(8'hF0);
        resetn = 1'b0;
        #1 chk_reset_values("midreset");
        model_reset();
        @(negedge CLOCK_50);
        resetn = 1'b1;
        @(negedge CLOCK_50);
        send(8'h1C);
        chk("postreset.make", 16'(note_on), 16'd1);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
